// File: rtl/mult_div_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mult_div_unit                                            |
// | Description : Sequential 32-bit multiply/divide unit with HI/LO        |
// |               registers. Signed and unsigned shift-add multiply,       |
// |               restoring divide, fixed 33-edge latency, MTHI/MTLO       |
// |               writes and a combinational MFHI/MFLO read port.          |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] r
);

  localparam logic [6:0] c_op_div   = 7'd7;
  localparam logic [6:0] c_op_divu  = 7'd8;
  localparam logic [6:0] c_op_mfhi  = 7'd9;
  localparam logic [6:0] c_op_mflo  = 7'd10;
  localparam logic [6:0] c_op_mthi  = 7'd11;
  localparam logic [6:0] c_op_mtlo  = 7'd12;
  localparam logic [6:0] c_op_mult  = 7'd13;
  localparam logic [6:0] c_op_multu = 7'd14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Working storage. For multiply r_work holds {partial product, remaining
  // multiplier bits}; for divide it holds {remainder, dividend/quotient}.
  logic [5:0]  r_cnt;
  logic [63:0] r_work;
  logic [31:0] r_opnd;     // multiplicand or divisor magnitude
  logic        r_is_div;
  logic        r_neg_q;    // product sign or quotient sign
  logic        r_neg_r;    // remainder sign (dividend sign)
  logic        r_dz;       // divide by zero
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [31:0] w_div_diff;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;

  assign w_is_mul = (op == c_op_mult) || (op == c_op_multu);
  assign w_is_div = (op == c_op_div)  || (op == c_op_divu);
  assign w_signed = (op == c_op_mult) || (op == c_op_div);

  // Signed ops work on magnitudes; -(2^31) still fits as an unsigned 32-bit value.
  assign w_a_mag = (w_signed && a[31]) ? -a : a;
  assign w_b_mag = (w_signed && b[31]) ? -b : b;

  // One shift-add step: conditionally add the multiplicand to the upper half,
  // then shift the whole product right, carry included.
  assign w_mul_sum = {1'b0, r_work[63:32]} + (r_work[0] ? {1'b0, r_opnd} : 33'd0);

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits. The shifted remainder can need 33 bits,
  // but the difference, when taken, is always below the divisor.
  assign w_div_shift = {r_work[63:32], r_work[31]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_diff  = w_div_shift[31:0] - r_opnd;

  // Sign correction. Divide by zero leaves the remainder equal to |a|, so the
  // usual remainder correction recovers a; the quotient is forced to all ones.
  assign w_prod_fix = r_neg_q ? -r_work : r_work;
  assign w_quot_fix = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? -r_work[31:0] : r_work[31:0]);
  assign w_rem_fix  = r_neg_r ? -r_work[63:32] : r_work[63:32];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: 32 iteration edges, then one fix-up edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && w_is_mul) begin
          w_state_nxt = S_MUL;
        end else if (start && w_is_div) begin
          w_state_nxt = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == 6'd31) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result write-back and MTHI/MTLO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 6'd0;
      r_work   <= 64'd0;
      r_opnd   <= 32'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_mul || w_is_div) begin
              r_cnt    <= 6'd0;
              r_work   <= {32'd0, w_a_mag};
              r_opnd   <= w_b_mag;
              r_is_div <= w_is_div;
              r_neg_q  <= w_signed & (a[31] ^ b[31]);
              r_neg_r  <= w_signed & a[31];
              r_dz     <= w_is_div && (b == 32'd0);
            end else if (op == c_op_mthi) begin
              r_hi <= a;
            end else if (op == c_op_mtlo) begin
              r_lo <= a;
            end
          end
        end
        S_MUL: begin
          r_work <= {w_mul_sum, r_work[31:1]};
          r_cnt  <= r_cnt + 6'd1;
        end
        S_DIV: begin
          r_work <= {(w_div_ge ? w_div_diff : w_div_shift[31:0]), r_work[30:0], w_div_ge};
          r_cnt  <= r_cnt + 6'd1;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quot_fix;
          end else begin
            r_hi <= w_prod_fix[63:32];
            r_lo <= w_prod_fix[31:0];
          end
        end
        default: begin
          r_cnt <= 6'd0;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Read port for MFHI/MFLO.
  always_comb begin
    r = 32'd0;
    if (op == c_op_mfhi) begin
      r = r_hi;
    end else if (op == c_op_mflo) begin
      r = r_lo;
    end
  end

endmodule
`default_nettype wire
